// File: rtl/alarm_pkg.sv
// Shared constants and FSM state type for the multi-alarm scheduler.
package alarm_pkg;

    localparam int MINUTES_PER_DAY = 1440;
    localparam int MINUTE_W        = 11;

    typedef enum logic [1:0] {
        StIdle,
        StRinging,
        StSnoozed
    } alarm_state_t;

endpackage

// File: rtl/alarm_match_encoder.sv
// Per-slot minute comparators followed by a lowest-index priority encoder.
module alarm_match_encoder
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2
) (
    input  logic [NUM_ALARMS-1:0][MINUTE_W-1:0] i_Slot_Minutes,
    input  logic [NUM_ALARMS-1:0]               i_Slot_Enable,
    input  logic [MINUTE_W-1:0]                 i_Time_Minutes,
    output logic                                o_Hit,
    output logic [IDX_W-1:0]                    o_Idx
);

    // Scan from the top down so the lowest matching slot is the last one written.
    always_comb begin
        o_Hit = 1'b0;
        o_Idx = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (i_Slot_Enable[k] && (i_Slot_Minutes[k] == i_Time_Minutes)) begin
                o_Hit = 1'b1;
                o_Idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/multi_alarm_scheduler.sv
// Multi-slot alarm engine with snooze and automatic ring timeout.
module multi_alarm_scheduler
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS     = 4,
    parameter int SNOOZE_MINUTES = 9,
    parameter int RING_TIMEOUT   = 10,
    parameter int MAX_SNOOZE     = 3,
    localparam int IDX_W         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Minute_Tick,
    input  logic [MINUTE_W-1:0]   i_Time_Minutes,
    input  logic                  i_Wr_En,
    input  logic [IDX_W-1:0]      i_Wr_Idx,
    input  logic [MINUTE_W-1:0]   i_Wr_Minutes,
    input  logic                  i_Wr_Enable,
    input  logic                  i_Snooze,
    input  logic                  i_Dismiss,
    output logic                  o_Ringing,
    output logic [IDX_W-1:0]      o_Ring_Idx,
    output logic                  o_Snoozed,
    output logic [NUM_ALARMS-1:0] o_Enabled_Mask,
    output logic                  o_Wr_Err
);

    localparam logic [11:0] DAY_12    = 12'(MINUTES_PER_DAY);
    localparam logic [11:0] SNOOZE_12 = 12'(SNOOZE_MINUTES);
    localparam logic [5:0]  TIMEOUT_6 = 6'(RING_TIMEOUT);
    localparam logic [3:0]  MAX_SNZ_4 = 4'(MAX_SNOOZE);

    logic [NUM_ALARMS-1:0][MINUTE_W-1:0] r_Slot_Min;
    logic [NUM_ALARMS-1:0]               r_Slot_En;
    logic                                r_Wr_Err;

    alarm_state_t     r_State;
    logic [IDX_W-1:0] r_Ring_Idx;
    logic [3:0]       r_Snooze_Cnt;
    logic [5:0]       r_Ring_Cnt;
    logic [11:0]      r_Deadline;
    logic             r_Ringing;
    logic             r_Snoozed;

    logic             w_Wr_Ok;
    logic             w_Hit;
    logic [IDX_W-1:0] w_Hit_Idx;
    logic [11:0]      w_Sum;
    logic [11:0]      w_Deadline;
    logic             w_At_Deadline;
    logic             w_Timeout;

    assign w_Wr_Ok = (int'(i_Wr_Idx) < NUM_ALARMS) && ({1'b0, i_Wr_Minutes} < DAY_12);

    // Snooze deadline wraps across midnight; the current time is always below one day.
    assign w_Sum         = {1'b0, i_Time_Minutes} + SNOOZE_12;
    assign w_Deadline    = (w_Sum >= DAY_12) ? (w_Sum - DAY_12) : w_Sum;
    assign w_At_Deadline = ({1'b0, i_Time_Minutes} == r_Deadline);
    assign w_Timeout     = i_Minute_Tick && ((r_Ring_Cnt + 6'd1) == TIMEOUT_6);

    alarm_match_encoder #(
        .NUM_ALARMS (NUM_ALARMS),
        .IDX_W      (IDX_W)
    ) u_match (
        .i_Slot_Minutes (r_Slot_Min),
        .i_Slot_Enable  (r_Slot_En),
        .i_Time_Minutes (i_Time_Minutes),
        .o_Hit          (w_Hit),
        .o_Idx          (w_Hit_Idx)
    );

    // Slot storage: accepted writes land next edge, rejected ones pulse the error flag.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_Slot_Min <= '0;
            r_Slot_En  <= '0;
            r_Wr_Err   <= 1'b0;
        end else begin
            r_Wr_Err <= i_Wr_En && !w_Wr_Ok;
            if (i_Wr_En && w_Wr_Ok) begin
                r_Slot_Min[i_Wr_Idx] <= i_Wr_Minutes;
                r_Slot_En[i_Wr_Idx]  <= i_Wr_Enable;
            end
        end
    end

    // Ring FSM; priority within a cycle is dismiss, timeout, snooze, then match.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_State      <= StIdle;
            r_Ring_Idx   <= '0;
            r_Snooze_Cnt <= '0;
            r_Ring_Cnt   <= '0;
            r_Deadline   <= '0;
            r_Ringing    <= 1'b0;
            r_Snoozed    <= 1'b0;
        end else begin
            unique case (r_State)
                StIdle: begin
                    if (i_Minute_Tick && w_Hit) begin
                        r_State      <= StRinging;
                        r_Ring_Idx   <= w_Hit_Idx;
                        r_Snooze_Cnt <= '0;
                        r_Ring_Cnt   <= '0;
                        r_Ringing    <= 1'b1;
                    end
                end
                StRinging: begin
                    if (i_Dismiss || w_Timeout) begin
                        r_State   <= StIdle;
                        r_Ringing <= 1'b0;
                    end else if (i_Snooze && (r_Snooze_Cnt < MAX_SNZ_4)) begin
                        r_State      <= StSnoozed;
                        r_Deadline   <= w_Deadline;
                        r_Snooze_Cnt <= r_Snooze_Cnt + 4'd1;
                        r_Ringing    <= 1'b0;
                        r_Snoozed    <= 1'b1;
                    end else if (i_Minute_Tick) begin
                        r_Ring_Cnt <= r_Ring_Cnt + 6'd1;
                    end
                end
                StSnoozed: begin
                    if (i_Dismiss) begin
                        r_State   <= StIdle;
                        r_Snoozed <= 1'b0;
                    end else if (i_Minute_Tick && w_At_Deadline) begin
                        r_State    <= StRinging;
                        r_Ring_Cnt <= '0;
                        r_Ringing  <= 1'b1;
                        r_Snoozed  <= 1'b0;
                    end else if (i_Minute_Tick && w_Hit) begin
                        r_State      <= StRinging;
                        r_Ring_Idx   <= w_Hit_Idx;
                        r_Snooze_Cnt <= '0;
                        r_Ring_Cnt   <= '0;
                        r_Ringing    <= 1'b1;
                        r_Snoozed    <= 1'b0;
                    end
                end
                default: begin
                    r_State   <= StIdle;
                    r_Ringing <= 1'b0;
                    r_Snoozed <= 1'b0;
                end
            endcase
        end
    end

    assign o_Ringing      = r_Ringing;
    assign o_Ring_Idx     = r_Ring_Idx;
    assign o_Snoozed      = r_Snoozed;
    assign o_Enabled_Mask = r_Slot_En;
    assign o_Wr_Err       = r_Wr_Err;

endmodule

// File: tb/tb_multi_alarm_scheduler.sv
// Directed bench for multi_alarm_scheduler with a queue-based scoreboard.
module tb_multi_alarm_scheduler;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Minute_Tick = 1'b0;
    logic [10:0] i_Time_Minutes = '0;
    logic        i_Wr_En = 1'b0;
    logic [1:0]  i_Wr_Idx = '0;
    logic [10:0] i_Wr_Minutes = '0;
    logic        i_Wr_Enable = 1'b0;
    logic        i_Snooze = 1'b0;
    logic        i_Dismiss = 1'b0;
    logic        o_Ringing;
    logic [1:0]  o_Ring_Idx;
    logic        o_Snoozed;
    logic [3:0]  o_Enabled_Mask;
    logic        o_Wr_Err;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        string      tag;
        logic       ringing;
        logic [1:0] idx;
        logic       snoozed;
        logic [3:0] mask;
        logic       wr_err;
    } exp_t;

    exp_t sb[$];

    multi_alarm_scheduler #(
        .NUM_ALARMS     (4),
        .SNOOZE_MINUTES (9),
        .RING_TIMEOUT   (10),
        .MAX_SNOOZE     (3)
    ) dut (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .i_Minute_Tick  (i_Minute_Tick),
        .i_Time_Minutes (i_Time_Minutes),
        .i_Wr_En        (i_Wr_En),
        .i_Wr_Idx       (i_Wr_Idx),
        .i_Wr_Minutes   (i_Wr_Minutes),
        .i_Wr_Enable    (i_Wr_Enable),
        .i_Snooze       (i_Snooze),
        .i_Dismiss      (i_Dismiss),
        .o_Ringing      (o_Ringing),
        .o_Ring_Idx     (o_Ring_Idx),
        .o_Snoozed      (o_Snoozed),
        .o_Enabled_Mask (o_Enabled_Mask),
        .o_Wr_Err       (o_Wr_Err)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic r, input logic [1:0] idx,
                        input logic s, input logic [3:0] m, input logic e);
        exp_t x;
        x.tag = tag; x.ringing = r; x.idx = idx; x.snoozed = s; x.mask = m; x.wr_err = e;
        sb.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        if (sb.size() == 0) begin
            cmp("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            cmp({x.tag, ".ringing"}, 32'(o_Ringing), 32'(x.ringing));
            cmp({x.tag, ".idx"}, 32'(o_Ring_Idx), 32'(x.idx));
            cmp({x.tag, ".snoozed"}, 32'(o_Snoozed), 32'(x.snoozed));
            cmp({x.tag, ".mask"}, 32'(o_Enabled_Mask), 32'(x.mask));
            cmp({x.tag, ".wr_err"}, 32'(o_Wr_Err), 32'(x.wr_err));
        end
    endtask

    // Advance one clock, then release every pulse input.
    task automatic cycle();
        @(posedge i_Clk);
        #1;
        i_Minute_Tick = 1'b0;
        i_Wr_En = 1'b0;
        i_Snooze = 1'b0;
        i_Dismiss = 1'b0;
    endtask

    task automatic wr(input logic [1:0] idx, input logic [10:0] m, input logic en);
        i_Wr_En = 1'b1; i_Wr_Idx = idx; i_Wr_Minutes = m; i_Wr_Enable = en;
    endtask

    task automatic tick(input logic [10:0] m);
        i_Time_Minutes = m; i_Minute_Tick = 1'b1;
    endtask

    initial begin
        // Reset state
        push("reset", 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        #2; check_out();
        cycle(); cycle();
        i_Reset = 1'b0;
        cycle();

        // Write and tick in the same cycle: the new slot is not yet visible
        wr(2'd2, 11'd420, 1'b1); tick(11'd420);
        push("same_cycle_write", 1'b0, 2'd0, 1'b0, 4'b0100, 1'b0);
        cycle(); check_out();

        tick(11'd420);
        push("ring_slot2", 1'b1, 2'd2, 1'b0, 4'b0100, 1'b0);
        cycle(); check_out();

        i_Dismiss = 1'b1;
        push("dismiss", 1'b0, 2'd2, 1'b0, 4'b0100, 1'b0);
        cycle(); check_out();

        // Two slots at the same minute: lowest index wins
        wr(2'd1, 11'd600, 1'b1); cycle();
        wr(2'd3, 11'd600, 1'b1); cycle();
        tick(11'd600);
        push("priority", 1'b1, 2'd1, 1'b0, 4'b1110, 1'b0);
        cycle(); check_out();
        i_Dismiss = 1'b1; cycle();

        // Snooze across midnight: 1435 + 9 wraps to 4
        wr(2'd0, 11'd1435, 1'b1); cycle();
        tick(11'd1435);
        push("ring_slot0", 1'b1, 2'd0, 1'b0, 4'b1111, 1'b0);
        cycle(); check_out();
        i_Snooze = 1'b1;
        push("snooze1", 1'b0, 2'd0, 1'b1, 4'b1111, 1'b0);
        cycle(); check_out();
        i_Snooze = 1'b1;
        push("snooze_in_snoozed", 1'b0, 2'd0, 1'b1, 4'b1111, 1'b0);
        cycle(); check_out();
        tick(11'd1439);
        push("not_deadline", 1'b0, 2'd0, 1'b1, 4'b1111, 1'b0);
        cycle(); check_out();
        tick(11'd4);
        push("wrap_deadline", 1'b1, 2'd0, 1'b0, 4'b1111, 1'b0);
        cycle(); check_out();

        // Second and third snoozes, then the fourth is refused
        i_Snooze = 1'b1; cycle();
        tick(11'd13);
        push("deadline13", 1'b1, 2'd0, 1'b0, 4'b1111, 1'b0);
        cycle(); check_out();
        i_Snooze = 1'b1; cycle();
        tick(11'd22);
        push("deadline22", 1'b1, 2'd0, 1'b0, 4'b1111, 1'b0);
        cycle(); check_out();
        i_Snooze = 1'b1;
        push("snooze4_ignored", 1'b1, 2'd0, 1'b0, 4'b1111, 1'b0);
        cycle(); check_out();

        // Timeout: nine ticks keep ringing, the tenth stops it
        for (int t = 23; t < 32; t++) begin
            tick(11'(t)); cycle();
        end
        push("pre_timeout", 1'b1, 2'd0, 1'b0, 4'b1111, 1'b0);
        check_out();
        tick(11'd32);
        push("timeout", 1'b0, 2'd0, 1'b0, 4'b1111, 1'b0);
        cycle(); check_out();

        // Out-of-range minutes rejected
        wr(2'd0, 11'd1440, 1'b0);
        push("wr_err_pulse", 1'b0, 2'd0, 1'b0, 4'b1111, 1'b1);
        cycle(); check_out();
        push("wr_err_clear", 1'b0, 2'd0, 1'b0, 4'b1111, 1'b0);
        cycle(); check_out();

        // Snooze and dismiss together: dismiss wins
        tick(11'd600); cycle();
        i_Snooze = 1'b1; i_Dismiss = 1'b1;
        push("snooze_dismiss", 1'b0, 2'd1, 1'b0, 4'b1111, 1'b0);
        cycle(); check_out();

        // New match while snoozed rings the new slot
        tick(11'd420); cycle();
        i_Time_Minutes = 11'd420; i_Snooze = 1'b1; cycle();
        tick(11'd600);
        push("new_match_snoozed", 1'b1, 2'd1, 1'b0, 4'b1111, 1'b0);
        cycle(); check_out();

        // Disabling the active slot leaves the ring running
        wr(2'd1, 11'd600, 1'b0);
        push("disable_active", 1'b1, 2'd1, 1'b0, 4'b1101, 1'b0);
        cycle(); check_out();

        // Asynchronous reset while ringing
        i_Reset = 1'b1;
        push("async_reset", 1'b0, 2'd0, 1'b0, 4'b0000, 1'b0);
        #1; check_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_alarm_scheduler.md
# multi_alarm_scheduler

Parametrised alarm engine that replaces the single-alarm compare/ring path of the alarm clock with NUM_ALARMS independently programmable alarms, snooze, and automatic ring timeout. Sits in the 5 MHz domain between the time counter (minute-of-day value plus minute-tick pulse) and the alarm output driver. The master controller writes alarm slots over a simple write port and forwards debounced snooze/dismiss pulses.

## Interface
Parameters:
- NUM_ALARMS, 4: alarm slots, 1..16.
- SNOOZE_MINUTES, 9: snooze length in minutes, 1..59.
- RING_TIMEOUT, 10: minute ticks of continuous ringing before auto-stop, 1..59.
- MAX_SNOOZE, 3: snoozes allowed per ring event, 0..15.

Ports:
- i_Clk, in, 1: 5 MHz system clock.
- i_Reset, in, 1: asynchronous, active-high reset.
- i_Minute_Tick, in, 1: one-cycle pulse when the time counter enters a new minute.
- i_Time_Minutes, in, 11: current minute of day, 0..1439, already updated when i_Minute_Tick is high.
- i_Wr_En, in, 1: one-cycle slot write strobe.
- i_Wr_Idx, in, $clog2(NUM_ALARMS) (min 1): slot to write.
- i_Wr_Minutes, in, 11: alarm minute of day.
- i_Wr_Enable, in, 1: slot enable written with the minutes.
- i_Snooze, in, 1: one-cycle snooze pulse.
- i_Dismiss, in, 1: one-cycle dismiss pulse.
- o_Ringing, out, 1: alarm sounding.
- o_Ring_Idx, out, $clog2(NUM_ALARMS): slot that caused the current ring/snooze.
- o_Snoozed, out, 1: snooze pending.
- o_Enabled_Mask, out, NUM_ALARMS: per-slot enable bits.
- o_Wr_Err, out, 1: one-cycle pulse on rejected write.

## Operation
- Slot storage: minutes[11] + enable per slot; reset to minutes 0, disabled.
- Write: i_Wr_En with i_Wr_Minutes < 1440 and i_Wr_Idx < NUM_ALARMS updates slot next edge; otherwise slot unchanged and o_Wr_Err pulses next cycle.
- Match: on i_Minute_Tick, slot k matches if enabled and minutes == i_Time_Minutes; lowest matching index wins.
- FSM states IDLE, RINGING, SNOOZED:
  - IDLE: match -> RINGING, latch idx, clear snooze count and ring-tick counter.
  - RINGING: i_Dismiss -> IDLE. i_Snooze with count < MAX_SNOOZE -> SNOOZED, deadline = (i_Time_Minutes + SNOOZE_MINUTES) mod 1440, count+1. i_Snooze at count == MAX_SNOOZE ignored. Each i_Minute_Tick increments ring counter; reaching RING_TIMEOUT -> IDLE. New matches ignored.
  - SNOOZED: i_Dismiss -> IDLE. Tick with i_Time_Minutes == deadline -> RINGING, ring counter cleared, idx and count kept. Tick with new slot match (other than deadline) -> RINGING for new idx, count cleared. i_Snooze ignored.
- Priority on one cycle: i_Dismiss > timeout > i_Snooze > match.
- Disabling or rewriting the active slot does not stop the current ring/snooze.
- Deadline arithmetic in 12 bits, subtract 1440 if ≥ 1440 (wraps 23:55+9 -> 00:04).

## Timing
- All outputs registered. Reset values: o_Ringing 0, o_Snoozed 0, o_Ring_Idx 0, o_Enabled_Mask 0, o_Wr_Err 0, FSM IDLE.
- Tick at edge t -> o_Ringing high after edge t+1 (1-cycle latency); same for snooze/dismiss effect.
- Write at cycle t is visible to a match at cycle t+1, not t.
- Reset mid-ring: immediate drop of o_Ringing/o_Snoozed, all slots cleared.

## Structure
- Shared package alarm_pkg: MINUTES_PER_DAY = 1440, MINUTE_W = 11, FSM state enum.
- Sub-module alarm_match_encoder: combinational NUM_ALARMS comparators + lowest-index priority encoder (outputs hit, idx).

## Test plan
- Write slot 2 = 420 enabled; tick at 420 -> o_Ringing=1, o_Ring_Idx=2 one cycle later; dismiss -> 0 next cycle.
- Slots 1 and 3 both = 600; tick at 600 -> o_Ring_Idx=1.
- Slot 0 = 1435; ring, snooze at 1435 -> o_Snoozed=1; tick at 4 -> ringing again, idx 0.
- MAX_SNOOZE=3: fourth snooze ignored; RING_TIMEOUT ticks later o_Ringing=0 with no dismiss.
- Write i_Wr_Minutes=1440 -> o_Wr_Err pulse, mask unchanged; snooze and dismiss same cycle -> IDLE.
- Assert i_Reset while ringing -> o_Ringing=0 and o_Enabled_Mask=0 without clock edge.
